// File: rtl/btn_reset_conditioner_pkg.sv
// Shared types and default timing constants for the board-side button/reset conditioner.
package otter_io_pkg;
  typedef enum logic [1:0] {HOLD, STRETCH, IDLE} rst_state_t;

  localparam int DB_CYCLES_DEF   = 16;
  localparam int RST_STRETCH_DEF = 8;
endpackage

// File: rtl/btn_reset_conditioner_if.sv
// Button pins in, debounced levels/edges and core reset out.
interface btn_reset_conditioner_if #(parameter int N_BTN = 5);
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_rise;
  logic [N_BTN-1:0] btn_fall;
  logic             sys_rst;

  modport master (output btn_raw, input btn_level, btn_rise, btn_fall, sys_rst);
  modport slave  (input btn_raw, output btn_level, btn_rise, btn_fall, sys_rst);
endinterface

// File: rtl/btn_reset_conditioner_debounce.sv
// One button channel: 2-flop synchroniser, stability counter, level and edge pulses.
module btn_debounce
  import otter_io_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);
  localparam int CW = $clog2(DB_CYCLES);

  logic          s1, s2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      s1   <= raw;
      s2   <= s1;
      rise <= 1'b0;
      fall <= 1'b0;
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DB_CYCLES - 1)) begin
        // s2 has disagreed with level for DB_CYCLES edges: accept it
        level <= s2;
        cnt   <= '0;
        rise  <= s2;
        fall  <= ~s2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/btn_reset_conditioner.sv
// Debounces N_BTN buttons and generates a stretched core reset from rst or the reset button.
module btn_reset_conditioner
  import otter_io_pkg::*;
#(
  parameter int N_BTN       = 5,
  parameter int DB_CYCLES   = DB_CYCLES_DEF,
  parameter int RST_EN      = 1,
  parameter int RST_IDX     = 4,
  parameter int RST_STRETCH = RST_STRETCH_DEF
) (
  input logic                    clk,
  input logic                    rst,
  btn_reset_conditioner_if.slave bus
);
  localparam int SW = (RST_STRETCH > 1) ? $clog2(RST_STRETCH) : 1;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk   (clk),
      .rst   (rst),
      .raw   (bus.btn_raw[i]),
      .level (bus.btn_level[i]),
      .rise  (bus.btn_rise[i]),
      .fall  (bus.btn_fall[i])
    );
  end

  logic          req;
  rst_state_t    state, state_nxt;
  logic [SW-1:0] scnt, scnt_nxt;

  // req comes from the registered debounced level, so it is glitch-free
  assign req = (RST_EN != 0) && bus.btn_level[RST_IDX];

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= HOLD;
      scnt        <= '0;
      bus.sys_rst <= 1'b1;
    end else begin
      state       <= state_nxt;
      scnt        <= scnt_nxt;
      bus.sys_rst <= (state_nxt != IDLE);
    end
  end

  always_comb begin
    state_nxt = state;
    scnt_nxt  = scnt;
    case (state)
      HOLD: begin
        if (!req) begin
          state_nxt = STRETCH;
          scnt_nxt  = '0;
        end
      end
      STRETCH: begin
        if (req)                                 state_nxt = HOLD;
        else if (scnt == SW'(RST_STRETCH - 1))   state_nxt = IDLE;
        else                                     scnt_nxt  = scnt + 1'b1;
      end
      IDLE: begin
        if (req) state_nxt = HOLD;
      end
      default: state_nxt = HOLD;
    endcase
  end
endmodule

// File: tb/tb_btn_reset_conditioner.sv
// Directed bench: expected output vectors are queued per edge and compared after each rising edge.
module tb_btn_reset_conditioner;
  localparam int N = 5;

  logic clk;
  logic rst;

  btn_reset_conditioner_if #(.N_BTN(N)) if1 ();
  btn_reset_conditioner_if #(.N_BTN(N)) if2 ();

  btn_reset_conditioner #(
    .N_BTN(N), .DB_CYCLES(4), .RST_EN(1), .RST_IDX(4), .RST_STRETCH(3)
  ) dut (.clk(clk), .rst(rst), .bus(if1.slave));

  // longer stretch so a re-press can land while the FSM is still stretching
  btn_reset_conditioner #(
    .N_BTN(N), .DB_CYCLES(4), .RST_EN(1), .RST_IDX(4), .RST_STRETCH(12)
  ) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [15:0] exp;
    bit          d2;
  } sb_t;

  sb_t sb[$];
  int  checks   = 0;
  int  failures = 0;

  // vector: {sys_rst, fall[4:0], rise[4:0], level[4:0]}
  task automatic step(input logic [N-1:0] raw, input logic [N-1:0] raw2, input logic r,
                      input logic [15:0] exp1, input bit chk2, input logic exp2, input string tag);
    sb_t e;
    logic [15:0] obs;
    if1.btn_raw = raw;
    if2.btn_raw = raw2;
    rst         = r;
    e.tag = tag; e.exp = exp1; e.d2 = 1'b0;
    sb.push_back(e);
    if (chk2) begin
      e.tag = {tag, "_d2"}; e.exp = {15'b0, exp2}; e.d2 = 1'b1;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = e.d2 ? {15'b0, if2.sys_rst}
                 : {if1.sys_rst, if1.btn_fall, if1.btn_rise, if1.btn_level};
      checks++;
      assert (obs === e.exp) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  initial begin
    logic [6:0] bounce;
    logic [15:0] x;
    bounce = 7'b1111011; // bit i = raw[1] on edge i: 1,1,0,1,1,1,1

    // power-up reset, then stretch release
    for (int i = 0; i < 3; i++)
      step(5'h00, 5'h00, 1'b1, 16'h8000, 1'b1, 1'b1, $sformatf("por_%0d", i));
    for (int i = 0; i < 6; i++)
      step(5'h00, 5'h00, 1'b0, (i < 3) ? 16'h8000 : 16'h0000, 1'b0, 1'b0,
           $sformatf("stretch_%0d", i));

    // clean press/release on channel 0
    for (int i = 0; i < 7; i++) begin
      x = (i < 5) ? 16'h0000 : (i == 5) ? 16'h0021 : 16'h0001;
      step(5'h01, 5'h00, 1'b0, x, 1'b0, 1'b0, $sformatf("press0_%0d", i));
    end
    for (int i = 0; i < 7; i++) begin
      x = (i < 5) ? 16'h0001 : (i == 5) ? 16'h0400 : 16'h0000;
      step(5'h00, 5'h00, 1'b0, x, 1'b0, 1'b0, $sformatf("rel0_%0d", i));
    end

    // bounce on channel 1: single rise only after the glitch has settled
    for (int i = 0; i < 11; i++) begin
      x = (i < 8) ? 16'h0000 : (i == 8) ? 16'h0042 : 16'h0002;
      step((i < 7) ? {3'b0, bounce[i], 1'b0} : 5'h02, 5'h00, 1'b0, x, 1'b0, 1'b0,
           $sformatf("bounce1_%0d", i));
    end
    for (int i = 0; i < 7; i++) begin
      x = (i < 5) ? 16'h0002 : (i == 5) ? 16'h0800 : 16'h0000;
      step(5'h00, 5'h00, 1'b0, x, 1'b0, 1'b0, $sformatf("rel1_%0d", i));
    end

    // reset button while idle
    for (int i = 0; i < 21; i++) begin
      if (i < 5)       x = 16'h0000;
      else if (i == 5) x = 16'h0210;
      else if (i < 15) x = 16'h8010;
      else if (i == 15) x = 16'hC000;
      else if (i < 19) x = 16'h8000;
      else             x = 16'h0000;
      step((i < 10) ? 5'h10 : 5'h00, 5'h00, 1'b0, x, 1'b0, 1'b0, $sformatf("rstbtn_%0d", i));
    end

    // re-press during stretch (long-stretch instance): no early drop, full stretch after final release
    for (int i = 0; i < 45; i++)
      step(5'h00, ((i < 10) || (i >= 14 && i < 24)) ? 5'h10 : 5'h00, 1'b0, 16'h0000,
           1'b1, (i >= 6 && i < 42), $sformatf("repress_%0d", i));

    // rst in the middle of a debounce count on channel 2
    for (int i = 0; i < 12; i++) begin
      if (i < 4)       x = 16'h0000;
      else if (i < 8)  x = 16'h8000;
      else if (i < 10) x = 16'h0000;
      else if (i == 10) x = 16'h0084;
      else             x = 16'h0004;
      step(5'h04, 5'h00, (i == 4), x, 1'b0, 1'b0, $sformatf("rstmid_%0d", i));
    end

    // simultaneous edges on channels 0, 2, 3 (2 already high)
    for (int i = 0; i < 7; i++) begin
      x = (i < 5) ? 16'h0004 : (i == 5) ? 16'h012D : 16'h000D;
      step(5'h0D, 5'h00, 1'b0, x, 1'b0, 1'b0, $sformatf("multi_rise_%0d", i));
    end
    for (int i = 0; i < 7; i++) begin
      x = (i < 5) ? 16'h000D : (i == 5) ? 16'h3400 : 16'h0000;
      step(5'h00, 5'h00, 1'b0, x, 1'b0, 1'b0, $sformatf("multi_fall_%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
